// File: rtl/mxc_pulse_gen_if.sv
// Signal bundle between a pulse-generator client and mxc_pulse_gen.
// The master side drives the control inputs and the divider output.
// The slave side (the pulse generator) drives the pulse, strobe and status.
interface mxc_pulse_gen_if #(
  parameter int CNT_W = 16
) ();

  logic             en;
  logic             clr;
  logic             div_in;
  logic [7:0]       delay;
  logic [7:0]       width;
  logic             invert;
  logic             pulse_out;
  logic             trig_out;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output en,
    output clr,
    output div_in,
    output delay,
    output width,
    output invert,
    input  pulse_out,
    input  trig_out,
    input  busy,
    input  overrun,
    input  edge_cnt
  );

  modport slave (
    input  en,
    input  clr,
    input  div_in,
    input  delay,
    input  width,
    input  invert,
    output pulse_out,
    output trig_out,
    output busy,
    output overrun,
    output edge_cnt
  );

endinterface

// File: rtl/mxc_pulse_gen.sv
// Pulse generator fed by a multiplexed-counter frequency divider.
// Each accepted rising edge of div_in launches a delayed, fixed-width pulse
// and a one-cycle trigger strobe; edges are counted and edges that arrive
// while a pulse is still pending raise a sticky overrun flag.
module mxc_pulse_gen #(
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  mxc_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nxt;
  logic [7:0]       w_r;
  logic [7:0]       w_nxt;

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             counted;
  logic             can_accept;
  logic             accept;
  logic             ovr_ev;

  logic             acc_r;
  logic             trig_q;
  logic             pulse_q;
  logic             ovr_q;
  logic [CNT_W-1:0] edge_q;

  // Bring div_in into the clk domain; s1 is the metastability catcher, s2/s3 form the edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.div_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise       = s2 & ~s3;
  assign counted    = bus.en & rise;
  assign can_accept = (state == IDLE) | ((state == ACTIVE) & (cnt == 8'd0));
  assign accept     = counted & can_accept;
  assign ovr_ev     = counted & ~can_accept;

  // State, shared down-counter and latched width register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      w_r   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      w_r   <= w_nxt;
    end
  end

  // Next-state logic: delay only seeds the counter, so only width needs holding until ACTIVE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    w_nxt     = w_r;
    if (!bus.en) begin
      state_nxt = IDLE;
      cnt_nxt   = 8'd0;
    end else if (accept) begin
      w_nxt = bus.width;
      if (bus.width == 8'd0) begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end else if (bus.delay == 8'd0) begin
        state_nxt = ACTIVE;
        cnt_nxt   = bus.width - 8'd1;
      end else begin
        state_nxt = DELAY;
        cnt_nxt   = bus.delay - 8'd1;
      end
    end else begin
      case (state)
        DELAY: begin
          if (cnt != 8'd0) begin
            cnt_nxt = cnt - 8'd1;
          end else begin
            state_nxt = ACTIVE;
            cnt_nxt   = w_r - 8'd1;
          end
        end
        ACTIVE: begin
          if (cnt != 8'd0) begin
            cnt_nxt = cnt - 8'd1;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // Output registers: the strobe trails acceptance by two edges so it lines up with a zero-delay pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r   <= 1'b0;
      trig_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      acc_r   <= accept;
      trig_q  <= acc_r & bus.en;
      pulse_q <= (state == ACTIVE) ^ bus.invert;
    end
  end

  // Edge counter and sticky overrun; a coincident event wins over clear
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= '0;
      ovr_q  <= 1'b0;
    end else if (bus.clr) begin
      edge_q <= counted ? CNT_W'(1) : '0;
      ovr_q  <= ovr_ev;
    end else begin
      if (counted) begin
        edge_q <= edge_q + CNT_W'(1);
      end
      if (ovr_ev) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.trig_out  = trig_q;
  assign bus.busy      = (state != IDLE);
  assign bus.overrun   = ovr_q;
  assign bus.edge_cnt  = edge_q;

endmodule

// File: tb/tb_mxc_pulse_gen.sv
// Testbench for mxc_pulse_gen: directed scenarios followed by random traffic.
// A reference model describes each pulse as an interval of cycles and pushes
// the expected outputs per clock into a queue; a monitor pops and compares.
module tb_mxc_pulse_gen;

  localparam int CW = 8;

  typedef struct {
    logic          pulse;
    logic          trig;
    logic          busy;
    logic          ovr;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mxc_pulse_gen_if #(.CNT_W(CW)) bus ();

  mxc_pulse_gen #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  logic       cur_en  = 1'b0;
  logic [7:0] cur_d   = 8'd0;
  logic [7:0] cur_w   = 8'd0;
  logic       cur_inv = 1'b0;
  int         ph      = 0;

  initial begin
    bus.en     = 1'b0;
    bus.clr    = 1'b0;
    bus.div_in = 1'b0;
    bus.delay  = 8'd0;
    bus.width  = 8'd0;
    bus.invert = 1'b0;
  end

  // Reference model: a pulse accepted at edge E occupies edges E+D..E+D+W-1,
  // and a new edge may be accepted at any edge from E+D+W onwards.
  int   n      = 0;
  int   end_e  = 0;
  int   act_lo = 1;
  int   act_hi = 0;
  int   ecnt   = 0;
  logic m1 = 1'b0, m2 = 1'b0, m3 = 1'b0;
  logic acc_prev = 1'b0;
  logic ovr = 1'b0;

  initial begin
    exp_t e;
    logic rise_m, accept_m, ov_m;
    forever begin
      @(posedge clk);
      n++;
      if (rst) begin
        m1 = 1'b0; m2 = 1'b0; m3 = 1'b0;
        acc_prev = 1'b0;
        ovr = 1'b0;
        ecnt = 0;
        end_e = n;
        act_lo = n + 1;
        act_hi = n;
        e.pulse = 1'b0;
        e.trig = 1'b0;
      end else begin
        rise_m = m2 & ~m3;
        e.pulse = (((n - 1) >= act_lo) && ((n - 1) <= act_hi)) ^ bus.invert;
        e.trig = acc_prev & bus.en;
        accept_m = 1'b0;
        ov_m = 1'b0;
        if (bus.en) begin
          if (rise_m && (n >= end_e)) begin
            accept_m = 1'b1;
            if (bus.width != 8'd0) begin
              act_lo = n + int'(bus.delay);
              act_hi = act_lo + int'(bus.width) - 1;
              end_e = act_hi + 1;
            end else begin
              end_e = n;
            end
          end else if (rise_m) begin
            ov_m = 1'b1;
          end
        end else begin
          if (act_hi > n - 1) act_hi = n - 1;
          end_e = n;
        end
        acc_prev = accept_m;
        if (bus.clr) begin
          ecnt = (bus.en && rise_m) ? 1 : 0;
          ovr = ov_m;
        end else begin
          if (bus.en && rise_m) ecnt = (ecnt + 1) % (1 << CW);
          if (ov_m) ovr = 1'b1;
        end
        m3 = m2;
        m2 = m1;
        m1 = bus.div_in;
      end
      e.busy = (n < end_e);
      e.ovr = ovr;
      e.cnt = ecnt[CW-1:0];
      expq.push_back(e);
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs half a cycle after each edge
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        x = expq.pop_front();
        checkOutput("pulse_out", int'(bus.pulse_out), int'(x.pulse));
        checkOutput("trig_out", int'(bus.trig_out), int'(x.trig));
        checkOutput("busy", int'(bus.busy), int'(x.busy));
        checkOutput("overrun", int'(bus.overrun), int'(x.ovr));
        checkOutput("edge_cnt", int'(bus.edge_cnt), int'(x.cnt));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic c, input logic dv,
                               input logic [7:0] d, input logic [7:0] w, input logic inv);
    @(posedge clk);
    #1;
    rst        = r;
    bus.en     = e;
    bus.clr    = c;
    bus.div_in = dv;
    bus.delay  = d;
    bus.width  = w;
    bus.invert = inv;
  endtask

  task automatic tick(input logic dv, input logic c);
    applyStimulus(1'b0, cur_en, c, dv, cur_d, cur_w, cur_inv);
  endtask

  task automatic idleFor(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0);
  endtask

  task automatic edgeOnce();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
  endtask

  task automatic runDiv(input int ratio, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick((ph % ratio) < (ratio / 2), 1'b0);
      ph++;
    end
  endtask

  task automatic resetFor(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, cur_en, 1'b0, 1'b0, cur_d, cur_w, cur_inv);
  endtask

  initial begin
    resetFor(3);
    $display("[TB] basic pulse");
    cur_en = 1'b1; cur_d = 8'd3; cur_w = 8'd4; cur_inv = 1'b0;
    idleFor(5);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    idleFor(20);

    $display("[TB] zero delay and zero width");
    cur_d = 8'd0; cur_w = 8'd2;
    edgeOnce();
    idleFor(10);
    cur_w = 8'd0;
    edgeOnce();
    idleFor(10);

    $display("[TB] overrun and clear");
    cur_d = 8'd0; cur_w = 8'd20; ph = 0;
    runDiv(8, 80);
    tick(1'b0, 1'b1);
    idleFor(30);

    $display("[TB] retrigger and invert");
    cur_d = 8'd0; cur_w = 8'd8; ph = 0;
    runDiv(8, 64);
    cur_inv = 1'b1;
    runDiv(8, 64);
    idleFor(12);
    cur_inv = 1'b0;
    idleFor(12);

    $display("[TB] counter wrap and clear with edge");
    cur_d = 8'd0; cur_w = 8'd1; ph = 0;
    runDiv(2, 600);
    tick((ph % 2) < 1, 1'b1); ph++;
    tick((ph % 2) < 1, 1'b1); ph++;
    runDiv(2, 10);
    idleFor(6);

    $display("[TB] reset mid-pulse");
    cur_d = 8'd0; cur_w = 8'd20;
    edgeOnce();
    idleFor(6);
    resetFor(1);
    idleFor(6);

    $display("[TB] enable drop during delay");
    cur_d = 8'd10; cur_w = 8'd5;
    edgeOnce();
    idleFor(4);
    cur_en = 1'b0; ph = 0;
    runDiv(4, 20);
    cur_en = 1'b1;
    idleFor(12);

    $display("[TB] random traffic");
    for (int seg = 0; seg < 60; seg++) begin
      int ratio;
      int len;
      ratio   = $urandom_range(2, 12);
      len     = $urandom_range(20, 80);
      cur_d   = 8'($urandom_range(0, 12));
      cur_w   = 8'($urandom_range(0, 12));
      cur_inv = 1'($urandom_range(0, 1));
      cur_en  = (($urandom % 8) != 0);
      if (($urandom % 15) == 0) resetFor(1);
      for (int i = 0; i < len; i++) begin
        tick((ph % ratio) < (ratio / 2), ($urandom % 50) == 0);
        ph++;
      end
    end
    cur_en = 1'b1;
    idleFor(30);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
